// File: rtl/mem_resp_pkg.sv
// Shared types and helpers for the data-memory responder: FSM encoding, lane
// geometry and the address legality check.
package mem_resp_pkg;

    localparam int BYTE_LANES = 4;
    localparam int WORD_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // A request is illegal when it is not word aligned or its word index lies beyond the storage.
    function automatic logic addr_error(input logic [31:0] addr, input logic [31:0] depth);
        logic [31:0] word_idx;
        word_idx = {2'b00, addr[31:2]};
        return (addr[1:0] != 2'b00) || (word_idx >= depth);
    endfunction

endpackage

// File: rtl/bytewrite_ram.sv
// Word-wide storage with a combinational read port and per-byte-lane write enables.
// Contents are deliberately never reset.
module bytewrite_ram
    import mem_resp_pkg::*;
#(
    parameter int MEM_DEPTH = 1024,
    parameter int AW        = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         addr,
    input  logic [31:0]           wdata,
    input  logic [BYTE_LANES-1:0] be,
    output logic [31:0]           rdata
);

    logic [31:0] mem [MEM_DEPTH];

    assign rdata = mem[addr];

    // Byte-lane write: only lanes with their enable set are updated.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < BYTE_LANES; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder: accepts one word request, holds it for LATENCY-1 wait
// states, commits the access on entry to RESP and holds the response until taken.
module data_mem_responder
    import mem_resp_pkg::*;
#(
    parameter int MEM_DEPTH = 1024,
    parameter int LATENCY   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int         AW           = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic       SINGLE_CYCLE = (LATENCY == 1);
    localparam logic [3:0] LAT_INIT     = 4'(LATENCY - 1);

    state_t      state;
    logic [3:0]  count;
    logic        cap_we;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [3:0]  cap_be;

    logic        enter_resp;
    logic        acc_we;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic [3:0]  acc_be;
    logic        acc_err;
    logic        ram_we;
    logic [31:0] ram_rdata;

    // Decide whether this edge is the commit edge that enters RESP.
    always_comb begin
        enter_resp = 1'b0;
        case (state)
            IDLE:    enter_resp = req_valid && SINGLE_CYCLE;
            WAIT:    enter_resp = (count == 4'd1);
            default: enter_resp = 1'b0;
        endcase
    end

    // With single-cycle latency the commit happens on the acceptance edge, so the live request is used.
    always_comb begin
        if (state == IDLE) begin
            acc_we    = req_we;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
            acc_be    = req_be;
        end else begin
            acc_we    = cap_we;
            acc_addr  = cap_addr;
            acc_wdata = cap_wdata;
            acc_be    = cap_be;
        end
    end

    assign acc_err = addr_error(acc_addr, 32'(MEM_DEPTH));
    assign ram_we  = enter_resp && acc_we && !acc_err && !reset;

    bytewrite_ram #(
        .MEM_DEPTH (MEM_DEPTH),
        .AW        (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (acc_addr[AW+1:2]),
        .wdata (acc_wdata),
        .be    (acc_be),
        .rdata (ram_rdata)
    );

    // Control FSM, wait-state counter and request capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            count     <= 4'd0;
            req_ready <= 1'b1;
            cap_we    <= 1'b0;
            cap_addr  <= 32'd0;
            cap_wdata <= 32'd0;
            cap_be    <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        cap_we    <= req_we;
                        cap_addr  <= req_addr;
                        cap_wdata <= req_wdata;
                        cap_be    <= req_be;
                        req_ready <= 1'b0;
                        if (SINGLE_CYCLE) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            count <= LAT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (count == 4'd1) begin
                        state <= RESP;
                        count <= 4'd0;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    count     <= 4'd0;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

    // Response registers: loaded at the commit edge, held until the handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'd0;
        end else if (enter_resp) begin
            resp_valid <= 1'b1;
            resp_err   <= acc_err;
            resp_rdata <= (acc_err || acc_we) ? 32'd0 : ram_rdata;
        end else if ((state == RESP) && resp_ready) begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'd0;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench: three responders (LATENCY 2, 1, 15) driven by directed
// vector tables, hand-written corner sequences and randomized traffic vs a model.
module tb_data_mem_responder;

    localparam int NI = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid  [NI];
    logic        req_ready  [NI];
    logic        req_we     [NI];
    logic [31:0] req_addr   [NI];
    logic [31:0] req_wdata  [NI];
    logic [3:0]  req_be     [NI];
    logic        resp_valid [NI];
    logic        resp_ready [NI];
    logic [31:0] resp_rdata [NI];
    logic        resp_err   [NI];

    int lat_of_inst [NI] = '{2, 1, 15};
    int n_tests = 0;
    int n_fail  = 0;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        data_mem_responder #(
            .MEM_DEPTH (1024),
            .LATENCY   ((g == 0) ? 2 : ((g == 1) ? 1 : 15))
        ) u_dut (
            .clk        (clk),
            .reset      (reset),
            .req_valid  (req_valid[g]),
            .req_ready  (req_ready[g]),
            .req_we     (req_we[g]),
            .req_addr   (req_addr[g]),
            .req_wdata  (req_wdata[g]),
            .req_be     (req_be[g]),
            .resp_valid (resp_valid[g]),
            .resp_ready (resp_ready[g]),
            .resp_rdata (resp_rdata[g]),
            .resp_err   (resp_err[g])
        );
    end

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          hold;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // One complete transaction with optional response back-pressure of 'hold' cycles.
    task automatic do_txn(input int i, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be, input int hold,
                          input logic [31:0] exp_rdata, input logic exp_err, input string tag);
        int k;
        int lat;
        logic [31:0] rd;
        k = 0;
        while (!req_ready[i] && k < 50) begin
            @(posedge clk); #1; k++;
        end
        check({tag, " req_ready idle"}, 32'(req_ready[i]), 32'd1);
        req_valid[i] = 1'b1;
        req_we[i]    = we;
        req_addr[i]  = addr;
        req_wdata[i] = wdata;
        req_be[i]    = be;
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
        req_we[i]    = 1'($urandom);
        req_addr[i]  = $urandom;
        req_wdata[i] = $urandom;
        req_be[i]    = 4'($urandom);
        lat = 1;
        while (!resp_valid[i] && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(lat_of_inst[i]));
        check({tag, " rdata"}, resp_rdata[i], exp_rdata);
        check({tag, " err"}, 32'(resp_err[i]), 32'(exp_err));
        rd = resp_rdata[i];
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check({tag, " hold valid"}, 32'(resp_valid[i]), 32'd1);
            check({tag, " hold rdata"}, resp_rdata[i], exp_rdata);
            check({tag, " hold err"}, 32'(resp_err[i]), 32'(exp_err));
            check({tag, " hold req_ready"}, 32'(req_ready[i]), 32'd0);
        end
        resp_ready[i] = 1'b1;
        @(posedge clk); #1;
        resp_ready[i] = 1'b0;
        check({tag, " valid after hs"}, 32'(resp_valid[i]), 32'd0);
        check({tag, " req_ready after hs"}, 32'(req_ready[i]), 32'd1);
    endtask

    // Continuous reads with resp_ready held high: handshakes must be LATENCY+1 apart.
    task automatic tput(input int i);
        int last;
        int cnt;
        int l;
        l = lat_of_inst[i];
        last = -1;
        cnt = 0;
        resp_ready[i] = 1'b1;
        req_valid[i]  = 1'b1;
        req_we[i]     = 1'b0;
        req_addr[i]   = 32'h0000_0100;
        for (int c = 0; c < 5 * (l + 1) + 2; c++) begin
            if (resp_valid[i] && resp_ready[i]) begin
                if (last >= 0) check($sformatf("period L=%0d", l), 32'(c - last), 32'(l + 1));
                last = c;
                cnt++;
            end
            @(posedge clk); #1;
        end
        req_valid[i] = 1'b0;
        repeat (l + 2) begin
            @(posedge clk); #1;
        end
        resp_ready[i] = 1'b0;
        check($sformatf("handshake count L=%0d", l), 32'(cnt >= 4), 32'd1);
    endtask

    // Randomized traffic on a 16-word window against an array model of the storage.
    task automatic rand_test(input int i, input int n);
        logic [31:0] model [16];
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_rd;
        logic [3:0]  be;
        logic        we;
        logic        err;
        int          r;
        int          w;
        for (int k = 0; k < 16; k++) begin
            model[k] = $urandom;
            do_txn(i, 1'b1, 32'h100 + 32'(k * 4), model[k], 4'hF, 0, 32'd0, 1'b0, "init");
        end
        for (int t = 0; t < n; t++) begin
            r    = $urandom_range(0, 9);
            w    = $urandom_range(0, 15);
            addr = 32'h100 + 32'(w * 4);
            err  = 1'b0;
            if (r == 0) begin
                addr = addr + 32'($urandom_range(1, 3));
                err  = 1'b1;
            end else if (r == 1) begin
                addr = ($urandom_range(0, 1) == 0) ? 32'h1000 + 32'($urandom_range(0, 255) * 4)
                                                   : 32'hFFFF_FFFC;
                err  = 1'b1;
            end
            we     = 1'($urandom_range(0, 1));
            data   = $urandom;
            be     = 4'($urandom_range(0, 15));
            exp_rd = (err || we) ? 32'd0 : model[w];
            do_txn(i, we, addr, data, be, $urandom_range(0, 2), exp_rd, err,
                   $sformatf("rand L=%0d #%0d", lat_of_inst[i], t));
            if (!err && we) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) model[w][8*b +: 8] = data[8*b +: 8];
                end
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL global timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'h0, 0, 32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h0000_0010, 32'h1122_3344, 4'h5, 0, 32'h0000_0000, 1'b0};
        vecs[3]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'h0, 5, 32'hDE22_BE44, 1'b0};
        vecs[4]  = '{1'b1, 32'h0000_0000, 32'hA5A5_A5A5, 4'hF, 0, 32'h0000_0000, 1'b0};
        vecs[5]  = '{1'b0, 32'h0000_0013, 32'h0000_0000, 4'h0, 0, 32'h0000_0000, 1'b1};
        vecs[6]  = '{1'b1, 32'h0000_1000, 32'hFFFF_FFFF, 4'hF, 0, 32'h0000_0000, 1'b1};
        vecs[7]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 4'h0, 0, 32'hA5A5_A5A5, 1'b0};
        vecs[8]  = '{1'b1, 32'h0000_0000, 32'h1234_5678, 4'h0, 0, 32'h0000_0000, 1'b0};
        vecs[9]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 4'h0, 0, 32'hA5A5_A5A5, 1'b0};
        vecs[10] = '{1'b1, 32'h0000_0003, 32'h0000_0000, 4'hF, 0, 32'h0000_0000, 1'b1};
        vecs[11] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 4'h0, 0, 32'hA5A5_A5A5, 1'b0};
        vecs[12] = '{1'b1, 32'h0000_0FFC, 32'h7777_8888, 4'hF, 0, 32'h0000_0000, 1'b0};
        vecs[13] = '{1'b0, 32'h0000_0FFC, 32'h0000_0000, 4'h0, 2, 32'h7777_8888, 1'b0};
        vecs[14] = '{1'b1, 32'h0000_0020, 32'h0BAD_C0DE, 4'hF, 0, 32'h0000_0000, 1'b0};
        vecs[15] = '{1'b0, 32'h0000_0020, 32'h0000_0000, 4'h0, 0, 32'h0BAD_C0DE, 1'b0};

        reset = 1'b1;
        for (int i = 0; i < NI; i++) begin
            req_valid[i]  = 1'b0;
            req_we[i]     = 1'b0;
            req_addr[i]   = 32'd0;
            req_wdata[i]  = 32'd0;
            req_be[i]     = 4'd0;
            resp_ready[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < NI; i++) begin
            check("reset resp_valid", 32'(resp_valid[i]), 32'd0);
            check("reset resp_err", 32'(resp_err[i]), 32'd0);
            check("reset resp_rdata", resp_rdata[i], 32'd0);
            check("reset req_ready", 32'(req_ready[i]), 32'd1);
        end

        for (int v = 0; v < 16; v++) begin
            do_txn(0, vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].be, vecs[v].hold,
                   vecs[v].exp_rdata, vecs[v].exp_err, $sformatf("vec%0d", v));
        end

        // Abort a write while it is still waiting; storage must keep the old word.
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b1;
        req_addr[0]  = 32'h0000_0020;
        req_wdata[0] = 32'hCAFE_F00D;
        req_be[0]    = 4'hF;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort resp_valid", 32'(resp_valid[0]), 32'd0);
        check("abort req_ready", 32'(req_ready[0]), 32'd1);
        repeat (4) begin
            @(posedge clk); #1;
            check("abort no response", 32'(resp_valid[0]), 32'd0);
        end
        do_txn(0, 1'b0, 32'h0000_0020, 32'd0, 4'h0, 0, 32'h0BAD_C0DE, 1'b0, "abort readback");

        for (int i = 0; i < NI; i++) tput(i);

        rand_test(0, 40);
        rand_test(1, 40);
        rand_test(2, 25);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
